bno055_sched: RTL and testbench
===============================

# bno055_sched

Sequencer and arbiter for the shared BNO055 I2C transaction engine (`bno055_read_write`).
- After reset it waits out the sensor power-on time, writes OPR_MODE, then waits the mode-switch time.
- It then polls the roll/pitch Euler registers (0x1C–0x1F) every poll period and presents complete 16-bit words atomically.
- Between frames it grants single-register host writes through a req/ack handshake.
- It sits between the top level (attitude encoder, debounced-switch logic) and the transaction engine, replacing ad-hoc sequencing in the top.

## Interface
Parameters:
- `POR_CYCLES`, 16_250_000: power-on wait, 650 ms at 25 MHz.
- `MODE_CYCLES`, 175_000: wait after the OPR_MODE write, 7 ms.
- `POLL_CYCLES`, 250_000: frame start period, 10 ms.
- `TIMEOUT_CYCLES`, 50_000: maximum wait for `i_done` per transaction, 2 ms.
- `OPR_MODE_VAL`, 8'h0B: mode written at init (NDOF_FMC_OFF).

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `o_opcode`  out  2  to engine; STOP=0, READ=1, WRITE=2.
- `o_reg_addr`  out  8  to engine.
- `o_tx_data`  out  8  to engine.
- `i_rx_data`  in  8  read byte from engine.
- `i_done`  in  1  one-cycle transaction-complete pulse from engine.
- `i_host_req`  in  1  host write request; held until ack.
- `i_host_addr`  in  8  host register address.
- `i_host_data`  in  8  host write data.
- `o_host_ack`  out  1  one-cycle pulse, host write finished.
- `o_host_err`  out  1  valid with `o_host_ack`; 1 = timed out.
- `o_roll`  out  16  {0x1D, 0x1C}.
- `o_pitch`  out  16  {0x1F, 0x1E}.
- `o_frame_valid`  out  1  one-cycle pulse when `o_roll`/`o_pitch` update.
- `o_ready`  out  1  init complete; stays high until reset.
- `o_err_count`  out  8  saturating timeout count.

## Operation
- Reset values: state S_POR_WAIT; `o_opcode`=STOP; `o_reg_addr`, `o_tx_data`, `o_roll`, `o_pitch` = 0; `o_host_ack`, `o_host_err`, `o_frame_valid`, `o_ready` = 0; `o_err_count` = 0; poll timer 0; frame-pending flag clear.
- Opcode rule: `o_opcode` is READ/WRITE for exactly one cycle (the ISSUE state) and STOP in every other cycle. `o_reg_addr` and `o_tx_data` hold their values until the next issue.
- States:
  - **S_POR_WAIT**: count `POR_CYCLES`, then go to S_CFG_ISSUE.
  - **S_CFG_ISSUE**: WRITE 0x3D with `OPR_MODE_VAL`; go to S_CFG_WAIT.
  - **S_CFG_WAIT**: on `i_done`, go to S_MODE_WAIT. On timeout, increment `o_err_count` and return to S_CFG_ISSUE (retry indefinitely).
  - **S_MODE_WAIT**: count `MODE_CYCLES`, set `o_ready`, start the poll timer, go to S_IDLE.
  - **S_IDLE**: if frame-pending, go to S_RD_ISSUE with byte index 0. Otherwise, if `i_host_req`, go to S_HOST_ISSUE. A frame has priority over the host when both are present in the same cycle.
  - **S_RD_ISSUE**: READ 0x1C+idx; go to S_RD_WAIT.
  - **S_RD_WAIT**: on `i_done`, store `i_rx_data` into shadow[idx]. If idx=3, go to S_FRAME_DONE; else idx+1 and go to S_RD_ISSUE. On timeout, increment errors, discard the shadow bytes, do not pulse valid, and go to S_IDLE.
  - **S_FRAME_DONE**: copy shadow to `o_roll`/`o_pitch`, pulse `o_frame_valid`, go to S_IDLE.
  - **S_HOST_ISSUE**: WRITE with `i_host_addr`/`i_host_data` sampled this cycle; go to S_HOST_WAIT.
  - **S_HOST_WAIT**: on `i_done`, pulse ack with err=0. On timeout, increment errors and pulse ack with err=1. Either way, go to S_IDLE.
- Poll timer:
  - Free-runs once `o_ready` is set; wraps every `POLL_CYCLES`.
  - Each wrap sets frame-pending; frame-pending is cleared on entry to S_RD_ISSUE idx 0.
  - A wrap during a frame or host transaction is remembered, not lost. Multiple wraps collapse into one pending frame.
- Host requests raised before `o_ready` wait; they are not acked.
- The block does not shadow the sensor mode. A host write to 0x3D is the host's responsibility.
- `o_err_count` saturates at 255.
- Reset asserted mid-transaction aborts immediately to reset values. The engine shares `i_rst`.

## Timing
- `i_done` seen in S_*_WAIT at cycle n → next READ issued at n+1 (within a frame).
- 4th-byte `i_done` at cycle n → `o_frame_valid` and new data at n+1.
- Host `i_done` at cycle n → `o_host_ack` high at n+1.
- Timeout fires when the wait counter reaches `TIMEOUT_CYCLES` with no `i_done`. If `i_done` and timeout occur in the same cycle, done wins.
- Cycles between frame starts: `POLL_CYCLES`, plus at most one host transaction when there is a collision.

## Structure
- Shared package `bno055_pkg`:
  - Opcode constants STOP/READ/WRITE.
  - Register addresses OPR_MODE 8'h3D and EUL_ROLL_LSB 8'h1C.
  - Mode constant NDOF_FMC_OFF 8'h0B.
  - State enum.
- One reusable sub-module `bno055_delay_timer` (load/count/expire down-counter), instanced for the POR/mode/timeout waits (shared, since the waits are mutually exclusive) and for the poll timer.

## Test plan
Run with small parameters (POR=10, MODE=5, POLL=200, TIMEOUT=30) and an engine model that returns `i_done` 8 cycles after an opcode, echoing a per-address byte.
- **Reset**: release reset → WRITE 0x3D/0x0B issued at cycle 10 after release; `o_ready` set 5 cycles after done; no opcode before.
- **Frame**: model returns 0x34/0x12/0x78/0x56 → `o_roll`=16'h1234, `o_pitch`=16'h5678, `o_frame_valid` one cycle wide, READ addresses exactly 0x1C,0x1D,0x1E,0x1F in order.
- **Host collision**: `i_host_req` (0x3F, 0x20) in the same cycle the poll timer wraps → frame runs first, then the host WRITE; `o_host_ack`=1 with `o_host_err`=0; next frame still starts on schedule.
- **Timeout**: model drops `i_done` for 0x1E → `o_err_count`=1, no `o_frame_valid`, outputs keep old values; the next frame completes normally.
- **Config retry**: drop `i_done` on the first OPR_MODE write → second WRITE 0x3D issued, `o_err_count`=1, `o_ready` set after the retried write completes.
- **Mid-frame reset**: assert reset during S_RD_WAIT idx 2 → all outputs return to reset values immediately, and the POR wait restarts.

Source files
------------

// File: rtl/bno055_pkg.sv
// Shared constants, opcodes and sequencer state encoding for the BNO055 sensor path.
package bno055_pkg;

  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [7:0] REG_OPR_MODE     = 8'h3D;
  localparam logic [7:0] REG_EUL_ROLL_LSB = 8'h1C;
  localparam logic [7:0] NDOF_FMC_OFF     = 8'h0B;

  typedef enum logic [3:0] {
    S_POR_WAIT,
    S_CFG_ISSUE,
    S_CFG_WAIT,
    S_MODE_WAIT,
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_FRAME_DONE,
    S_HOST_ISSUE,
    S_HOST_WAIT
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bno055_delay_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module bno055_delay_timer #(
  parameter int unsigned    W         = 32,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= RESET_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/bno055_sched.sv
// Init sequencer, Euler-angle poller and host-write arbiter in front of the
// shared BNO055 I2C transaction engine.
module bno055_sched
  import bno055_pkg::*;
#(
  parameter int unsigned POR_CYCLES     = 16_250_000,
  parameter int unsigned MODE_CYCLES    = 175_000,
  parameter int unsigned POLL_CYCLES    = 250_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter logic [7:0]  OPR_MODE_VAL   = NDOF_FMC_OFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [1:0]  o_opcode,
  output logic [7:0]  o_reg_addr,
  output logic [7:0]  o_tx_data,
  input  logic [7:0]  i_rx_data,
  input  logic        i_done,
  input  logic        i_host_req,
  input  logic [7:0]  i_host_addr,
  input  logic [7:0]  i_host_data,
  output logic        o_host_ack,
  output logic        o_host_err,
  output logic [15:0] o_roll,
  output logic [15:0] o_pitch,
  output logic        o_frame_valid,
  output logic        o_ready,
  output logic [7:0]  o_err_count
);

  localparam logic [31:0] POR_LOAD  = 32'(POR_CYCLES - 1);
  localparam logic [31:0] MODE_LOAD = 32'(MODE_CYCLES - 1);
  localparam logic [31:0] POLL_LOAD = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] TMO_LOAD  = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [1:0]  opcode_q, idx_q;
  logic [7:0]  reg_addr_q, tx_data_q, err_count_q;
  logic [7:0]  sh0_q, sh1_q, sh2_q;
  logic [15:0] roll_q, pitch_q;
  logic        host_ack_q, host_err_q, frame_valid_q, ready_q;
  logic        pending_q, pending_d;

  logic        wt_load, wt_expired, poll_expired, wrap, mode_done, frame_go;
  logic [31:0] wt_val;

  // One timer serves POR, mode and per-transaction waits: they never overlap.
  always_comb begin
    wt_load = 1'b0;
    wt_val  = TMO_LOAD;
    case (state_q)
      S_CFG_ISSUE, S_RD_ISSUE, S_HOST_ISSUE: wt_load = 1'b1;
      S_CFG_WAIT: if (i_done) begin
        wt_load = 1'b1;
        wt_val  = MODE_LOAD;
      end
      default: ;
    endcase
  end

  bno055_delay_timer #(.W(32), .RESET_VAL(POR_LOAD)) u_wait_tmr (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (wt_load),
    .load_val_i (wt_val),
    .en_i       (1'b1),
    .expired_o  (wt_expired)
  );

  assign mode_done = (state_q == S_MODE_WAIT) && wt_expired;
  assign wrap      = ready_q && poll_expired;
  assign frame_go  = pending_q || wrap;
  assign pending_d = (state_q == S_IDLE) ? 1'b0 : frame_go;

  bno055_delay_timer #(.W(32), .RESET_VAL('0)) u_poll_tmr (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (mode_done || wrap),
    .load_val_i (POLL_LOAD),
    .en_i       (ready_q),
    .expired_o  (poll_expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_POR_WAIT;
      opcode_q      <= OP_STOP;
      reg_addr_q    <= '0;
      tx_data_q     <= '0;
      idx_q         <= '0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      roll_q        <= '0;
      pitch_q       <= '0;
      host_ack_q    <= 1'b0;
      host_err_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      ready_q       <= 1'b0;
      err_count_q   <= '0;
      pending_q     <= 1'b0;
    end else begin
      opcode_q      <= OP_STOP;
      host_ack_q    <= 1'b0;
      host_err_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      pending_q     <= pending_d;
      // Issue-state outputs are registered on the edge entering that state.
      case (state_q)
        S_POR_WAIT: if (wt_expired) begin
          state_q    <= S_CFG_ISSUE;
          opcode_q   <= OP_WRITE;
          reg_addr_q <= REG_OPR_MODE;
          tx_data_q  <= OPR_MODE_VAL;
        end
        S_CFG_ISSUE: state_q <= S_CFG_WAIT;
        S_CFG_WAIT: begin
          if (i_done) begin
            state_q <= S_MODE_WAIT;
          end else if (wt_expired) begin
            err_count_q <= sat_inc8(err_count_q);
            state_q     <= S_CFG_ISSUE;
            opcode_q    <= OP_WRITE;
            reg_addr_q  <= REG_OPR_MODE;
            tx_data_q   <= OPR_MODE_VAL;
          end
        end
        S_MODE_WAIT: if (wt_expired) begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (frame_go) begin
            state_q    <= S_RD_ISSUE;
            idx_q      <= 2'd0;
            opcode_q   <= OP_READ;
            reg_addr_q <= REG_EUL_ROLL_LSB;
          end else if (i_host_req) begin
            state_q    <= S_HOST_ISSUE;
            opcode_q   <= OP_WRITE;
            reg_addr_q <= i_host_addr;
            tx_data_q  <= i_host_data;
          end
        end
        S_RD_ISSUE: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (i_done) begin
            case (idx_q)
              2'd0:    sh0_q <= i_rx_data;
              2'd1:    sh1_q <= i_rx_data;
              2'd2:    sh2_q <= i_rx_data;
              default: ;
            endcase
            if (idx_q == 2'd3) begin
              // Publish here so valid lands one cycle after the last byte.
              roll_q        <= {sh1_q, sh0_q};
              pitch_q       <= {i_rx_data, sh2_q};
              frame_valid_q <= 1'b1;
              state_q       <= S_FRAME_DONE;
            end else begin
              idx_q      <= idx_q + 2'd1;
              state_q    <= S_RD_ISSUE;
              opcode_q   <= OP_READ;
              reg_addr_q <= REG_EUL_ROLL_LSB + {6'd0, idx_q} + 8'd1;
            end
          end else if (wt_expired) begin
            err_count_q <= sat_inc8(err_count_q);
            state_q     <= S_IDLE;
          end
        end
        S_FRAME_DONE: state_q <= S_IDLE;
        S_HOST_ISSUE: state_q <= S_HOST_WAIT;
        S_HOST_WAIT: begin
          if (i_done) begin
            host_ack_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (wt_expired) begin
            host_ack_q  <= 1'b1;
            host_err_q  <= 1'b1;
            err_count_q <= sat_inc8(err_count_q);
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_POR_WAIT;
      endcase
    end
  end

  assign o_opcode      = opcode_q;
  assign o_reg_addr    = reg_addr_q;
  assign o_tx_data     = tx_data_q;
  assign o_host_ack    = host_ack_q;
  assign o_host_err    = host_err_q;
  assign o_roll        = roll_q;
  assign o_pitch       = pitch_q;
  assign o_frame_valid = frame_valid_q;
  assign o_ready       = ready_q;
  assign o_err_count   = err_count_q;

endmodule

// File: tb/tb_bno055_sched.sv
// Directed scoreboard bench for bno055_sched with a fixed-latency engine model.
module tb_bno055_sched;
  import bno055_pkg::*;

  localparam int unsigned POR = 10, MODE = 5, POLL = 200, TMO = 30;

  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  o_opcode;
  logic [7:0]  o_reg_addr, o_tx_data, o_err_count;
  logic [7:0]  i_rx_data = '0;
  logic        i_done = 1'b0;
  logic        i_host_req;
  logic [7:0]  i_host_addr, i_host_data;
  logic        o_host_ack, o_host_err, o_frame_valid, o_ready;
  logic [15:0] o_roll, o_pitch;

  always #5 clk = ~clk;

  bno055_sched #(
    .POR_CYCLES(POR), .MODE_CYCLES(MODE), .POLL_CYCLES(POLL),
    .TIMEOUT_CYCLES(TMO), .OPR_MODE_VAL(8'h0B)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .o_opcode(o_opcode), .o_reg_addr(o_reg_addr), .o_tx_data(o_tx_data),
    .i_rx_data(i_rx_data), .i_done(i_done),
    .i_host_req(i_host_req), .i_host_addr(i_host_addr), .i_host_data(i_host_data),
    .o_host_ack(o_host_ack), .o_host_err(o_host_err),
    .o_roll(o_roll), .o_pitch(o_pitch), .o_frame_valid(o_frame_valid),
    .o_ready(o_ready), .o_err_count(o_err_count)
  );

  // Engine model: i_done 8 cycles after the opcode cycle, per-address byte xor salt.
  logic [7:0] salt = '0, drop_addr = '0;
  int         drop_seq = 0, drop_seen = 0, eng_cnt = 0;
  logic [7:0] eng_addr = '0;
  bit         eng_drop = 1'b0;

  function automatic logic [7:0] eng_byte(input logic [7:0] a, input logic [7:0] s);
    case (a)
      8'h1C:   return 8'h34 ^ s;
      8'h1D:   return 8'h12 ^ s;
      8'h1E:   return 8'h78 ^ s;
      8'h1F:   return 8'h56 ^ s;
      default: return 8'hA5 ^ s;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt = 0;
      i_done <= 1'b0;
    end else begin
      i_done <= 1'b0;
      if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 0 && !eng_drop) begin
          i_done    <= 1'b1;
          i_rx_data <= eng_byte(eng_addr, salt);
        end
      end
      if (o_opcode != OP_STOP) begin
        eng_cnt  = 7;
        eng_addr = o_reg_addr;
        eng_drop = (drop_seq != drop_seen) && (o_reg_addr == drop_addr);
        if (eng_drop) drop_seen = drop_seq;
      end
    end
  end

  typedef struct packed { logic [1:0] op; logic [7:0] addr; logic [7:0] data; } op_t;
  typedef struct packed { logic [15:0] roll; logic [15:0] pitch; } frm_t;

  op_t  exp_ops[$];
  frm_t exp_frames[$];
  logic exp_acks[$];

  int checks = 0, errors = 0;
  int cyc = 0, op_cyc = 0, first_op_cyc = -1, start_cyc = 0, done_cyc = 0;
  int ready_cyc = 0, valid_cyc = 0, err_cyc = 0, nframes = 0, nacks = 0;
  logic       ready_prev = 1'b0;
  logic [7:0] err_prev = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic frm_t model_frame(input logic [7:0] s);
    return frm_t'{roll:  {eng_byte(8'h1D, s), eng_byte(8'h1C, s)},
                  pitch: {eng_byte(8'h1F, s), eng_byte(8'h1E, s)}};
  endfunction

  task automatic tick();
    op_t  eo;
    frm_t ef;
    @(posedge clk);
    #1;
    cyc++;
    if (i_done) done_cyc = cyc;
    if (o_ready && !ready_prev) ready_cyc = cyc;
    ready_prev = o_ready;
    if (o_err_count != err_prev) err_cyc = cyc;
    err_prev = o_err_count;
    if (o_opcode !== OP_STOP) begin
      op_cyc = cyc;
      if (first_op_cyc < 0) first_op_cyc = cyc;
      if (o_opcode == OP_READ && o_reg_addr == 8'h1C) start_cyc = cyc;
      if (exp_ops.size() == 0) begin
        check("op_unexpected", {22'd0, o_opcode, o_reg_addr}, 32'd0);
      end else begin
        eo = exp_ops.pop_front();
        check("op_code", 32'(o_opcode), 32'(eo.op));
        check("op_addr", 32'(o_reg_addr), 32'(eo.addr));
        if (eo.op == OP_WRITE) check("op_data", 32'(o_tx_data), 32'(eo.data));
      end
    end
    if (o_frame_valid) begin
      valid_cyc = cyc;
      nframes++;
      if (exp_frames.size() == 0) begin
        check("frame_unexpected", 32'(o_frame_valid), 32'd0);
      end else begin
        ef = exp_frames.pop_front();
        check("roll", 32'(o_roll), 32'(ef.roll));
        check("pitch", 32'(o_pitch), 32'(ef.pitch));
      end
    end
    if (o_host_ack) begin
      nacks++;
      if (exp_acks.size() == 0) check("ack_unexpected", 32'(o_host_ack), 32'd0);
      else check("host_err", 32'(o_host_err), 32'(exp_acks.pop_front()));
    end
  endtask

  task automatic check_reset_vals();
    check("rst_opcode", 32'(o_opcode), 32'(OP_STOP));
    check("rst_reg_addr", 32'(o_reg_addr), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_roll", 32'(o_roll), 32'd0);
    check("rst_pitch", 32'(o_pitch), 32'd0);
    check("rst_ack", 32'(o_host_ack), 32'd0);
    check("rst_err", 32'(o_host_err), 32'd0);
    check("rst_valid", 32'(o_frame_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_err_count", 32'(o_err_count), 32'd0);
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) exp_ops.push_back(op_t'{OP_READ, 8'(8'h1C + i), 8'h00});
  endtask

  task automatic wait_ready(input int lim);
    for (int i = 0; i < lim && !o_ready; i++) tick();
    check("ready_wait", 32'(o_ready), 32'd1);
  endtask

  task automatic wait_frame(input int n, input int lim);
    for (int i = 0; i < lim && nframes == n; i++) tick();
    check("frame_wait", 32'(nframes), 32'(n + 1));
  endtask

  initial begin
    int   n0, a0;
    frm_t f2;
    i_host_req = 1'b0; i_host_addr = '0; i_host_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();

    // Init: OPR_MODE write after POR, ready after mode wait.
    exp_ops.push_back(op_t'{OP_WRITE, 8'h3D, 8'h0B});
    rst = 1'b0; cyc = 0; first_op_cyc = -1;
    wait_ready(100);
    check("cfg_issue_cyc", 32'(first_op_cyc), 32'(POR));
    check("ready_cyc", 32'(ready_cyc), 32'(done_cyc + int'(MODE) + 1));

    // Frame 1: literal expected words.
    salt = 8'h00;
    push_reads(4);
    exp_frames.push_back(frm_t'{roll: 16'h1234, pitch: 16'h5678});
    wait_frame(nframes, 2 * POLL);
    check("frame1_start", 32'(start_cyc), 32'(ready_cyc + int'(POLL)));
    check("valid_after_done", 32'(valid_cyc), 32'(done_cyc + 1));
    tick();
    check("valid_width", 32'(o_frame_valid), 32'd0);

    // Host request in the wrap cycle: frame first, then the host write.
    salt = 8'h11;
    while (cyc < ready_cyc + 2 * int'(POLL) - 1) tick();
    i_host_req = 1'b1; i_host_addr = 8'h3F; i_host_data = 8'h20;
    push_reads(4);
    f2 = model_frame(salt);
    exp_frames.push_back(f2);
    exp_ops.push_back(op_t'{OP_WRITE, 8'h3F, 8'h20});
    exp_acks.push_back(1'b0);
    a0 = nacks;
    for (int i = 0; i < 2 * POLL && nacks == a0; i++) tick();
    i_host_req = 1'b0;
    check("host_ack_wait", 32'(nacks), 32'(a0 + 1));
    check("frame2_start", 32'(start_cyc), 32'(ready_cyc + 2 * int'(POLL)));
    check("host_after_frame", 32'(op_cyc), 32'(valid_cyc + 2));

    // Frame 3: byte 0x1E never completes.
    salt = 8'h22; drop_addr = 8'h1E; drop_seq++;
    push_reads(3);
    n0 = nframes;
    check("err_before_tmo", 32'(o_err_count), 32'd0);
    for (int i = 0; i < 2 * POLL && o_err_count == 8'd0; i++) tick();
    check("frame3_start", 32'(start_cyc), 32'(ready_cyc + 3 * int'(POLL)));
    check("tmo_err_count", 32'(o_err_count), 32'd1);
    check("tmo_cyc", 32'(err_cyc), 32'(op_cyc + int'(TMO) + 1));
    check("tmo_no_valid", 32'(nframes), 32'(n0));
    check("tmo_roll_hold", 32'(o_roll), 32'(f2.roll));
    check("tmo_pitch_hold", 32'(o_pitch), 32'(f2.pitch));

    // Frame 4 recovers on schedule.
    salt = 8'h33;
    push_reads(4);
    exp_frames.push_back(model_frame(salt));
    wait_frame(nframes, 2 * POLL);
    check("frame4_start", 32'(start_cyc), 32'(ready_cyc + 4 * int'(POLL)));

    // Frame 5: reset while waiting on byte index 2.
    salt = 8'h44;
    push_reads(3);
    n0 = nframes;
    for (int i = 0; i < 2 * POLL && exp_ops.size() != 0; i++) tick();
    check("rd_idx2_reached", 32'(exp_ops.size()), 32'd0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check_reset_vals();
    check("rst_no_valid", 32'(nframes), 32'(n0));

    // Re-init with first OPR_MODE write dropped and a host request held from reset.
    drop_addr = 8'h3D; drop_seq++;
    i_host_req = 1'b1; i_host_addr = 8'h10; i_host_data = 8'h55;
    exp_ops.push_back(op_t'{OP_WRITE, 8'h3D, 8'h0B});
    exp_ops.push_back(op_t'{OP_WRITE, 8'h3D, 8'h0B});
    exp_ops.push_back(op_t'{OP_WRITE, 8'h10, 8'h55});
    tick(); tick();
    rst = 1'b0; cyc = 0; first_op_cyc = -1;
    wait_ready(200);
    check("por_restart_cyc", 32'(first_op_cyc), 32'(POR));
    check("retry_issue_cyc", 32'(op_cyc), 32'(POR + TMO + 1));
    check("retry_err_count", 32'(o_err_count), 32'd1);
    check("retry_ready_cyc", 32'(ready_cyc), 32'(done_cyc + int'(MODE) + 1));
    exp_acks.push_back(1'b0);
    a0 = nacks;
    for (int i = 0; i < 100 && nacks == a0; i++) tick();
    i_host_req = 1'b0;
    check("early_host_ack", 32'(nacks), 32'(a0 + 1));
    check("early_host_cyc", 32'(op_cyc), 32'(ready_cyc + 1));
    repeat (5) tick();

    check("ops_left", 32'(exp_ops.size()), 32'd0);
    check("frames_left", 32'(exp_frames.size()), 32'd0);
    check("acks_left", 32'(exp_acks.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
